// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU class codes, opcodes, the packed control
// bundle carried by the ID/EX, EX/MEM and MEM/WB registers, and the per-edge
// action select used by the ID/EX register.
package pipeline_pkg;

  // ALU class produced by the control unit
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  // What the stage register does on the next clock edge
  typedef enum logic [1:0] {
    ActLoad,
    ActBubble,
    ActHold
  } stage_act_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags a hazard when the instruction in EX is a valid load whose non-zero
// destination (rt) is read by the valid instruction in decode.
// Ports:
//   i_ex_valid, i_ex_mem_read, i_ex_rt      : state of the EX slot
//   i_id_valid, i_id_rs, i_id_rt            : decode slot specifiers
//   i_id_reg_dst, i_id_mem_write, i_id_branch : decode controls that imply rt is read
//   o_hazard                                : load-use hazard this cycle
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_id_valid,
  input  logic              i_id_reg_dst,
  input  logic              i_id_mem_write,
  input  logic              i_id_branch,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  output logic              o_hazard
);

  logic w_uses_rt;
  logic w_match;

  // rt is a source for R-type, store data and branch compare
  assign w_uses_rt = i_id_reg_dst | i_id_mem_write | i_id_branch;
  assign w_match   = (i_ex_rt == i_id_rs) | ((i_ex_rt == i_id_rt) & w_uses_rt);
  assign o_hazard  = i_ex_valid & i_ex_mem_read & i_id_valid & (|i_ex_rt) & w_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, EX hold and
// a saturating bubble counter.
// Ports:
//   clk, reset                  : rising-edge clock, async active-high reset
//   id_*                        : decoded instruction from the control unit
//   flush                       : squash the instruction entering EX
//   ex_hold                     : EX busy, freeze this register
//   ex_*                        : registered copy presented to EX
//   stall_if_id                 : IF/ID and PC must hold this cycle
//   bubble_count                : saturating count of flush/hazard bubbles
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic [1:0]        id_alu_op,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic [1:0]        ex_alu_op,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  ctrl_t             w_id_ctrl;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_pc_plus4, r_rdata1, r_rdata2, r_imm;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [5:0]        r_funct;
  logic [CNT_W-1:0]  r_count;
  logic              w_hazard;
  logic              w_count_bubble;
  stage_act_e        w_act;

  always_comb begin
    w_id_ctrl            = '0;
    w_id_ctrl.reg_dst    = id_reg_dst;
    w_id_ctrl.branch     = id_branch;
    w_id_ctrl.mem_read   = id_mem_read;
    w_id_ctrl.mem_to_reg = id_mem_to_reg;
    w_id_ctrl.alu_op     = id_alu_op;
    w_id_ctrl.mem_write  = id_mem_write;
    w_id_ctrl.alu_src    = id_alu_src;
    w_id_ctrl.reg_write  = id_reg_write;
  end

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rt       (r_rt),
    .i_id_valid    (id_valid),
    .i_id_reg_dst  (id_reg_dst),
    .i_id_mem_write(id_mem_write),
    .i_id_branch   (id_branch),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .o_hazard      (w_hazard)
  );

  // Priority: flush > hold > hazard > empty decode slot > load
  always_comb begin
    w_act          = ActLoad;
    w_count_bubble = 1'b0;
    if (flush) begin
      w_act          = ActBubble;
      w_count_bubble = 1'b1;
    end else if (ex_hold) begin
      w_act = ActHold;
    end else if (w_hazard) begin
      w_act          = ActBubble;
      w_count_bubble = 1'b1;
    end else if (!id_valid) begin
      w_act = ActBubble;
    end
  end

  // Held low during reset so IF/ID is free to restart on release
  assign stall_if_id = ~reset & ~flush & (ex_hold | w_hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc_plus4 <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else begin
      case (w_act)
        ActLoad: begin
          r_valid    <= 1'b1;
          r_ctrl     <= w_id_ctrl;
          r_pc_plus4 <= id_pc_plus4;
          r_rdata1   <= id_rdata1;
          r_rdata2   <= id_rdata2;
          r_imm      <= id_imm;
          r_rs       <= id_rs;
          r_rt       <= id_rt;
          r_rd       <= id_rd;
          r_funct    <= id_funct;
        end
        ActBubble: begin
          // Whole slot zeroed so bubble contents are deterministic
          r_valid    <= 1'b0;
          r_ctrl     <= '0;
          r_pc_plus4 <= '0;
          r_rdata1   <= '0;
          r_rdata2   <= '0;
          r_imm      <= '0;
          r_rs       <= '0;
          r_rt       <= '0;
          r_rd       <= '0;
          r_funct    <= '0;
        end
        default: ;  // ActHold: retain
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_count_bubble && (r_count != CntMax)) begin
      r_count <= r_count + CntOne;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_reg_dst    = r_ctrl.reg_dst;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_rdata1     = r_rdata1;
  assign ex_rdata2     = r_rdata2;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;
  assign bubble_count  = r_count;

endmodule
